// File: rtl/peak_average.sv
// peak_average: averages per-batch peak reports (freq, magnitude, phase
// relative to peak 0) over 2^AVG_LOG2 good batches and streams one
// averaged NPEAKS-entry packet per group.
//
// Stream semantics: no backpressure. An input entry is taken on every
// rising edge where sink_valid is high. An output entry is present on
// every cycle where source_valid is high. Between output packets the data
// buses hold their last value.
module peak_average #(
    parameter int NPEAKS   = 4,
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic        sink_valid,
    input  logic [31:0] sink_freq,
    input  logic [31:0] sink_mag,
    input  logic [31:0] sink_phase,
    output logic        source_sop,
    output logic        source_eop,
    output logic        source_valid,
    output logic [31:0] source_freq,
    output logic [31:0] source_mag,
    output logic [31:0] source_dphase,
    output logic        frame_err
);
    localparam int IDXW = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
    localparam int AW   = 32 + AVG_LOG2;
    localparam int CW   = AVG_LOG2 + 1;
    localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(NPEAKS - 1);
    localparam logic [CW-1:0]     CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
    localparam logic signed [32:0] HALF_TURN = 33'sd46080;
    localparam logic signed [32:0] FULL_TURN = 33'sd92160;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    // Capture FSM state; kept as a named typed signal so checkers can bind to it.
    state_t          state, state_nxt;
    logic [IDXW-1:0] idx, idx_nxt;
    logic [31:0]     ref_phase, ref_nxt;

    // Per-entry decode of the incoming entry.
    logic [IDXW-1:0]    entry_idx;
    logic               is_last;
    logic signed [32:0] phase_diff;
    logic [31:0]        entry_dph;
    logic               accept;
    logic               commit;
    logic               err;
    logic               group_done;

    // Staged packet, accumulators and output snapshot.
    logic [31:0]          st_freq [NPEAKS];
    logic [31:0]          st_mag  [NPEAKS];
    logic [31:0]          st_dph  [NPEAKS];
    logic [31:0]          cv_freq [NPEAKS];
    logic [31:0]          cv_mag  [NPEAKS];
    logic [31:0]          cv_dph  [NPEAKS];
    logic signed [AW-1:0] acc_freq[NPEAKS];
    logic signed [AW-1:0] acc_mag [NPEAKS];
    logic signed [AW-1:0] acc_dph [NPEAKS];
    logic signed [AW-1:0] sum_freq[NPEAKS];
    logic signed [AW-1:0] sum_mag [NPEAKS];
    logic signed [AW-1:0] sum_dph [NPEAKS];
    logic [31:0]          avg_freq[NPEAKS];
    logic [31:0]          avg_mag [NPEAKS];
    logic [31:0]          avg_dph [NPEAKS];
    logic [31:0]          snap_freq[NPEAKS];
    logic [31:0]          snap_mag [NPEAKS];
    logic [31:0]          snap_dph [NPEAKS];
    logic [CW-1:0]        batch_cnt;
    logic                 out_busy;
    logic [IDXW-1:0]      out_idx;

    // Entry position and phase relative to peak 0, wrapped into [-180, 180) degrees.
    always_comb begin
        entry_idx  = sink_sop ? '0 : idx + IDXW'(1);
        is_last    = (entry_idx == LAST_IDX);
        phase_diff = $signed({sink_phase[31], sink_phase}) - $signed({ref_phase[31], ref_phase});
        if (phase_diff >= HALF_TURN) begin
            phase_diff = phase_diff - FULL_TURN;
        end else if (phase_diff < -HALF_TURN) begin
            phase_diff = phase_diff + FULL_TURN;
        end
        entry_dph = sink_sop ? 32'd0 : phase_diff[31:0];
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            ref_phase <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            ref_phase <= ref_nxt;
        end
    end

    // Capture FSM next state: a sop always (re)starts, any packet end returns to IDLE.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ref_nxt   = ref_phase;
        if (sink_valid && (sink_sop || state == S_COLLECT)) begin
            if (sink_sop) begin
                ref_nxt = sink_phase;
            end
            if (is_last || sink_eop) begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end else begin
                state_nxt = S_COLLECT;
                idx_nxt   = entry_idx;
            end
        end
    end

    // Capture FSM outputs: store strobe, commit on a well-framed eop, framing errors.
    always_comb begin
        accept     = sink_valid && (sink_sop || state == S_COLLECT);
        commit     = accept && is_last && sink_eop;
        err        = (sink_valid && sink_sop && state == S_COLLECT) ||
                     (accept && (is_last != sink_eop));
        group_done = commit && (batch_cnt == CNT_LAST);
    end

    // Stage each accepted entry at its index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NPEAKS; i++) begin
                st_freq[i] <= '0;
                st_mag[i]  <= '0;
                st_dph[i]  <= '0;
            end
        end else if (accept) begin
            st_freq[entry_idx] <= sink_freq;
            st_mag[entry_idx]  <= sink_mag;
            st_dph[entry_idx]  <= entry_dph;
        end
    end

    // Committed packet (the completing entry is not yet staged) and running sums.
    always_comb begin
        for (int i = 0; i < NPEAKS; i++) begin
            if (IDXW'(i) == entry_idx) begin
                cv_freq[i] = sink_freq;
                cv_mag[i]  = sink_mag;
                cv_dph[i]  = entry_dph;
            end else begin
                cv_freq[i] = st_freq[i];
                cv_mag[i]  = st_mag[i];
                cv_dph[i]  = st_dph[i];
            end
            sum_freq[i] = acc_freq[i] + AW'($signed(cv_freq[i]));
            sum_mag[i]  = acc_mag[i]  + AW'($signed(cv_mag[i]));
            sum_dph[i]  = acc_dph[i]  + AW'($signed(cv_dph[i]));
            avg_freq[i] = 32'(sum_freq[i] >>> AVG_LOG2);
            avg_mag[i]  = 32'(sum_mag[i]  >>> AVG_LOG2);
            avg_dph[i]  = 32'(sum_dph[i]  >>> AVG_LOG2);
        end
    end

    // Accumulate committed packets; clear when the group completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            batch_cnt <= '0;
            for (int i = 0; i < NPEAKS; i++) begin
                acc_freq[i] <= '0;
                acc_mag[i]  <= '0;
                acc_dph[i]  <= '0;
            end
        end else if (commit) begin
            if (group_done) begin
                batch_cnt <= '0;
                for (int i = 0; i < NPEAKS; i++) begin
                    acc_freq[i] <= '0;
                    acc_mag[i]  <= '0;
                    acc_dph[i]  <= '0;
                end
            end else begin
                batch_cnt <= batch_cnt + CW'(1);
                for (int i = 0; i < NPEAKS; i++) begin
                    acc_freq[i] <= sum_freq[i];
                    acc_mag[i]  <= sum_mag[i];
                    acc_dph[i]  <= sum_dph[i];
                end
            end
        end
    end

    // Output sequencer: entry 0 straight from the averages, the rest from the snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            source_valid  <= 1'b0;
            source_sop    <= 1'b0;
            source_eop    <= 1'b0;
            source_freq   <= '0;
            source_mag    <= '0;
            source_dphase <= '0;
            out_busy      <= 1'b0;
            out_idx       <= '0;
            for (int i = 0; i < NPEAKS; i++) begin
                snap_freq[i] <= '0;
                snap_mag[i]  <= '0;
                snap_dph[i]  <= '0;
            end
        end else if (group_done) begin
            for (int i = 0; i < NPEAKS; i++) begin
                snap_freq[i] <= avg_freq[i];
                snap_mag[i]  <= avg_mag[i];
                snap_dph[i]  <= avg_dph[i];
            end
            source_valid  <= 1'b1;
            source_sop    <= 1'b1;
            source_eop    <= (NPEAKS == 1);
            source_freq   <= avg_freq[0];
            source_mag    <= avg_mag[0];
            source_dphase <= avg_dph[0];
            out_busy      <= (NPEAKS > 1);
            out_idx       <= (NPEAKS > 1) ? IDXW'(1) : '0;
        end else if (out_busy) begin
            source_valid  <= 1'b1;
            source_sop    <= 1'b0;
            source_eop    <= (out_idx == LAST_IDX);
            source_freq   <= snap_freq[out_idx];
            source_mag    <= snap_mag[out_idx];
            source_dphase <= snap_dph[out_idx];
            out_busy      <= (out_idx != LAST_IDX);
            out_idx       <= out_idx + IDXW'(1);
        end else begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end
    end

    // One-cycle frame error pulse after the offending entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
        end
    end

endmodule
